// File: rtl/issue_pkg.sv
// Shared defaults and the entry layout for the issue queue.
package issue_pkg;
  localparam int IQ_DEPTH     = 8;
  localparam int IQ_TAG_W     = 3;
  localparam int IQ_WB_N      = 2;
  localparam int IQ_PAYLOAD_W = 16;

  typedef struct packed {
    logic                    valid;
    logic [IQ_TAG_W-1:0]     dst;
    logic [IQ_TAG_W-1:0]     src0;
    logic                    src0_rdy;
    logic [IQ_TAG_W-1:0]     src1;
    logic                    src1_rdy;
    logic [IQ_PAYLOAD_W-1:0] payload;
  } iq_entry_t;
endpackage

// File: rtl/iq_select.sv
// Oldest-ready picker: isolates the lowest set bit of the ready vector.
module iq_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]         i_req,
  output logic [DEPTH-1:0]         o_onehot,
  output logic [$clog2(DEPTH)-1:0] o_idx,
  output logic                     o_any
);
  localparam int IW = $clog2(DEPTH);

  assign o_onehot = i_req & (~i_req + DEPTH'(1));
  assign o_any    = |i_req;

  always_comb begin
    o_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (i_req[i]) o_idx = IW'(i);
  end
endmodule

// File: rtl/issue_queue.sv
// Compacting issue queue: oldest entry at index 0, tag-broadcast wakeup, oldest-ready select.
// Optional macro ISSUE_QUEUE_WAKEUP_BYPASS_EN: dispatching sources also see same-cycle broadcasts.
module issue_queue
  import issue_pkg::*;
#(
  parameter int DEPTH     = IQ_DEPTH,
  parameter int TAG_W     = IQ_TAG_W,
  parameter int WB_N      = IQ_WB_N,
  parameter int PAYLOAD_W = IQ_PAYLOAD_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [TAG_W-1:0]           disp_dst,
  input  logic [TAG_W-1:0]           disp_src0,
  input  logic [TAG_W-1:0]           disp_src1,
  input  logic                       disp_src0_rdy,
  input  logic                       disp_src1_rdy,
  input  logic [PAYLOAD_W-1:0]       disp_payload,
  input  logic [WB_N-1:0]            wb_valid,
  input  logic [WB_N*TAG_W-1:0]      wb_tag,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [TAG_W-1:0]           iss_dst,
  output logic [PAYLOAD_W-1:0]       iss_payload,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  // Same field layout as iq_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     dst;
    logic [TAG_W-1:0]     src0;
    logic                 src0_rdy;
    logic [TAG_W-1:0]     src1;
    logic                 src1_rdy;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t           r_q   [DEPTH];
  entry_t           w_nxt [DEPTH];
  entry_t           w_new;
  logic [CW-1:0]    r_count, w_count_nxt, w_wr_idx;
  logic [DEPTH-1:0] w_req, w_sel_oh, w_shift;
  logic [IW-1:0]    w_sel_idx;
  logic             w_any, w_iss_fire, w_disp_fire;

  function automatic logic wb_hit(input logic [TAG_W-1:0] t, input logic [WB_N-1:0] v,
                                  input logic [WB_N*TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WB_N; k++)
      if (v[k] && tags[k*TAG_W +: TAG_W] == t) hit = 1'b1;
    return hit;
  endfunction

  for (genvar i = 0; i < DEPTH; i++) begin : g_req
    assign w_req[i] = r_q[i].valid & r_q[i].src0_rdy & r_q[i].src1_rdy;
  end

  iq_select #(.DEPTH(DEPTH)) u_sel (
    .i_req    (w_req),
    .o_onehot (w_sel_oh),
    .o_idx    (w_sel_idx),
    .o_any    (w_any)
  );

  assign disp_ready  = !reset && !flush && (r_count < CW'(DEPTH));
  assign iss_valid   = !reset && !flush && w_any;
  assign w_iss_fire  = iss_valid && iss_ready;
  assign w_disp_fire = disp_valid && disp_ready;
  assign iss_dst     = r_q[w_sel_idx].dst;
  assign iss_payload = r_q[w_sel_idx].payload;
  assign count       = r_count;

  // Every slot at or above the issued one pulls from the slot above it.
  assign w_shift  = w_iss_fire ? ~(w_sel_oh - DEPTH'(1)) : '0;
  assign w_wr_idx = w_iss_fire ? r_count - CW'(1) : r_count;

  assign w_count_nxt = r_count + CW'(w_disp_fire) - CW'(w_iss_fire);

  always_comb begin
    w_new.valid   = 1'b1;
    w_new.dst     = disp_dst;
    w_new.src0    = disp_src0;
    w_new.src1    = disp_src1;
    w_new.payload = disp_payload;
`ifdef ISSUE_QUEUE_WAKEUP_BYPASS_EN
    w_new.src0_rdy = disp_src0_rdy | wb_hit(disp_src0, wb_valid, wb_tag);
    w_new.src1_rdy = disp_src1_rdy | wb_hit(disp_src1, wb_valid, wb_tag);
`else
    w_new.src0_rdy = disp_src0_rdy;
    w_new.src1_rdy = disp_src1_rdy;
`endif
  end

  // Shift first, then wake the entry in its new slot, then drop in the dispatch.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_nxt[i] = r_q[i];
      if (w_shift[i]) begin
        if (i == DEPTH - 1) w_nxt[i] = '0;
        else                w_nxt[i] = r_q[(i + 1) % DEPTH];
      end
      if (wb_hit(w_nxt[i].src0, wb_valid, wb_tag)) w_nxt[i].src0_rdy = 1'b1;
      if (wb_hit(w_nxt[i].src1, wb_valid, wb_tag)) w_nxt[i].src1_rdy = 1'b1;
      if (w_disp_fire && w_wr_idx == CW'(i)) w_nxt[i] = w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) r_q[i].valid <= 1'b0;
      r_count <= '0;
    end else begin
      r_q     <= w_nxt;
      r_count <= w_count_nxt;
    end
  end
endmodule
